// File: rtl/die_pkg.sv
// rtl/die_pkg.sv - shared states, codes and face helpers for the die sequencer
package die_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TUMBLE = 2'd1,
        SHOW   = 2'd2
    } state_t;

    localparam logic [7:0] BLANK_CODE = 8'hFF;
    localparam logic [7:0] LFSR_SEED  = 8'hA5;
    localparam logic [7:0] LFSR_TAPS  = 8'hB8;

    localparam logic [2:0] FACE_MIN = 3'd1;
    localparam logic [2:0] FACE_MAX = 3'd6;

    // (v[2:0] mod 6) + 1 without a divider: only 6 and 7 need folding back
    function automatic logic [2:0] face_from_lfsr(input logic [7:0] v);
        logic [2:0] low;
        low = v[2:0];
        return (low >= 3'd6) ? (low - 3'd5) : (low + 3'd1);
    endfunction

    function automatic logic [2:0] next_face(input logic [2:0] f);
        return (f == FACE_MAX) ? FACE_MIN : (f + 3'd1);
    endfunction

endpackage

// File: rtl/die_lfsr.sv
// rtl/die_lfsr.sv - free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1)
module die_lfsr
    import die_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr
);

    // Shift left every cycle; the seed is non-zero so the all-zero lockup state is never reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/die_roll_seq.sv
// rtl/die_roll_seq.sv - die roll sequencer feeding the 7-seg decoder; DIE_SHOW_BLINK_EN enables result blinking
module die_roll_seq
    import die_pkg::*;
#(
    parameter int TICK_DIV     = 4,
    parameter int TUMBLE_STEPS = 12,
    parameter int SHOW_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll_req,
    output logic       busy,
    output logic       done,
    output logic [2:0] result,
    output logic [7:0] disp_num
);

    localparam int CW = $clog2(TICK_DIV * TUMBLE_STEPS + 1);
    localparam int KW = (TUMBLE_STEPS > 1) ? $clog2(TUMBLE_STEPS) : 1;
    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(TUMBLE_STEPS - 1);
    localparam logic [SW-1:0] S_LAST = SW'((SHOW_CYCLES > 0) ? (SHOW_CYCLES - 1) : 0);

    state_t          state, state_n;
    logic [2:0]      face, face_n;
    logic [KW-1:0]   k, k_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [SW-1:0]   show_cnt, show_cnt_n;
    logic [2:0]      result_n;
    logic            done_n;
    logic            roll_req_d;
    logic            start;
    logic [7:0]      lfsr;
    logic [CW-1:0]   step_last;

    die_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    assign start     = roll_req & ~roll_req_d;
    // Step k lasts TICK_DIV*(k+1) cycles, so its final count is one less
    assign step_last = CW'(TICK_DIV * (int'(k) + 1) - 1);

`ifdef DIE_SHOW_BLINK_EN
    localparam int BP = 8 * TICK_DIV;
    localparam int BW = $clog2(BP);
    localparam logic [BW-1:0] B_LAST = BW'(BP - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    // Blink phase timer: held clear outside SHOW so every SHOW entry starts visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (state != SHOW) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == B_LAST) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`endif

    // State register plus step/face/show counters and the edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            face       <= FACE_MIN;
            k          <= '0;
            cnt        <= '0;
            show_cnt   <= '0;
            result     <= FACE_MIN;
            done       <= 1'b0;
            roll_req_d <= 1'b0;
        end else begin
            state      <= state_n;
            face       <= face_n;
            k          <= k_n;
            cnt        <= cnt_n;
            show_cnt   <= show_cnt_n;
            result     <= result_n;
            done       <= done_n;
            roll_req_d <= roll_req;
        end
    end

    // Next-state, face stepping and display selection
    always_comb begin
        state_n    = state;
        face_n     = face;
        k_n        = k;
        cnt_n      = cnt;
        show_cnt_n = show_cnt;
        result_n   = result;
        done_n     = 1'b0;
        busy       = 1'b0;
        disp_num   = BLANK_CODE;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = TUMBLE;
                    face_n  = face_from_lfsr(lfsr);
                    k_n     = '0;
                    cnt_n   = '0;
                end
            end

            TUMBLE: begin
                busy     = 1'b1;
                disp_num = {5'b0, face};
                if (cnt == step_last) begin
                    if (k == K_LAST) begin
                        result_n   = face;
                        done_n     = 1'b1;
                        state_n    = SHOW;
                        show_cnt_n = '0;
                    end else begin
                        face_n = next_face(face);
                        k_n    = k + 1'b1;
                        cnt_n  = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            SHOW: begin
`ifdef DIE_SHOW_BLINK_EN
                disp_num = blink_off ? BLANK_CODE : {5'b0, result};
`else
                disp_num = {5'b0, result};
`endif
                // A new roll beats the show timeout on the same edge
                if (start) begin
                    state_n = TUMBLE;
                    face_n  = face_from_lfsr(lfsr);
                    k_n     = '0;
                    cnt_n   = '0;
                end else if (SHOW_CYCLES > 0) begin
                    if (show_cnt == S_LAST) begin
                        state_n = IDLE;
                    end else begin
                        show_cnt_n = show_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/die_roll_seq.md
Name: die_roll_seq

Overview:
- Sequencer that drives the seven-segment decoder's 8-bit number input for the six-sided die.
- On a roll request it tumbles faces 1..6 with decelerating cadence, settles on a pseudo-random face, then holds or blanks it.
- Sits between the user button (already synchronised/debounced upstream) and the display decoder.
- The decoder blanks any code outside 0..9.

Parameters:
- TICK_DIV, 4: base step length in clk cycles; step k lasts TICK_DIV*(k+1) cycles.
- TUMBLE_STEPS, 12: number of tumble steps, ≥1.
- SHOW_CYCLES, 0: cycles to hold the result before blanking; 0 means hold until the next roll.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- roll_req  in  1  roll request; only a rising edge is acted on.
- busy  out  1  high while tumbling.
- done  out  1  one-cycle pulse when the result is settled.
- result  out  3  settled face 1..6; holds the last value.
- disp_num  out  8  code to the display decoder; 8'hFF = blank.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (all registers cleared immediately when rst_n=0):
  - state=IDLE, disp_num=8'hFF, busy=0, done=0, result=3'd1.
  - LFSR=8'hA5, roll_req_d=0.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clk in every state; never reaches 0.
- Start edge: start = roll_req & ~roll_req_d, where roll_req_d is roll_req registered.
  - start is honoured in IDLE and SHOW.
  - start is ignored in TUMBLE; a held-high roll_req never retriggers.
- IDLE:
  - disp_num=8'hFF, busy=0.
  - On start at edge T: next state TUMBLE.
  - face = (lfsr[2:0] mod 6)+1, using the LFSR value at edge T.
  - Step index k=0, cycle counter=0.
- TUMBLE:
  - busy=1, disp_num={5'b0, face}.
  - Counter counts TICK_DIV*(k+1) cycles per step.
  - At the end of step k < TUMBLE_STEPS-1: face = (face==6) ? 1 : face+1, k=k+1, counter=0.
  - At the end of the last step: result=face, done=1 for exactly one cycle, state=SHOW.
- Timing:
  - Total tumble duration D = TICK_DIV*TUMBLE_STEPS*(TUMBLE_STEPS+1)/2 cycles.
  - busy is high for cycles T+1..T+D.
  - done and SHOW begin at T+D+1.
  - result = ((start_face-1 + TUMBLE_STEPS-1) mod 6)+1.
- SHOW:
  - busy=0, disp_num={5'b0, result}.
  - If SHOW_CYCLES>0: after SHOW_CYCLES cycles go to IDLE (blank); result is retained.
  - A start in SHOW goes directly to TUMBLE; the show timer is discarded.
- Counter width: $clog2(TICK_DIV*TUMBLE_STEPS+1). It must not wrap inside any step.
- Simultaneous events: start on the same edge as the SHOW timeout → TUMBLE wins.
- Reset mid-tumble:
  - Immediate return to IDLE/blank; no done pulse.
  - result returns to 1.
- disp_num never carries 0 or 7..9 except 8'hFF blank; faces are 1..6 only.

Optional Feature:
- DIE_SHOW_BLINK_EN defined:
  - In SHOW, disp_num alternates between result and 8'hFF every 8*TICK_DIV cycles.
  - Blink starts in the visible phase on SHOW entry; the blink counter is reset on SHOW entry.
- Undefined: SHOW displays result steadily. No blink counter is synthesised.

Decomposition:
- Package die_pkg:
  - state enum {IDLE, TUMBLE, SHOW}.
  - BLANK_CODE=8'hFF, LFSR_SEED=8'hA5, LFSR_TAPS=8'hB8.
  - FACE_MIN=1, FACE_MAX=6.
- Sub-module die_lfsr (clk, rst_n, seed from package, 8-bit state out): free-running; reused for future multi-die variants.
- FSM, step counter and face logic live in die_roll_seq.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle (async) → outputs immediately disp_num=8'hFF, busy=0, done=0, result=1.
- Roll timing (TICK_DIV=2, TUMBLE_STEPS=3): single roll_req edge at T.
  - busy=1 at T+1..T+12.
  - done pulse only at T+13.
  - disp_num changes exactly at T+3 and T+7 (face steps).
  - result = start_face+2 wrapped in 1..6, and equals disp_num in SHOW.
- Face wrap: force start_face=5 via the known seed position with TUMBLE_STEPS=3 → faces 5,6,1; result=1.
- Ignore during tumble: toggle roll_req repeatedly during TUMBLE → no restart, same done time. Then a new rising edge in SHOW → TUMBLE restarts next cycle with no done pulse at that point.
- SHOW timeout (SHOW_CYCLES=5): after done, disp_num=result for 5 cycles, then 8'hFF; result is unchanged. Start on the timeout cycle → TUMBLE.
- Reset mid-tumble, then DIE_SHOW_BLINK_EN build:
  - rst_n low at step 1 → IDLE blank, no done pulse.
  - Blink build (TICK_DIV=2): disp_num toggles result/8'hFF every 16 cycles in SHOW.
